// File: rtl/idp_sequencer_pkg.sv
// Shared definitions for the integer datapath sequencer: FSM states,
// instruction word field positions and ALU operation codes.
package idp_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IMM = 2'd1,
    EXEC     = 2'd2
  } state_e;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int W_HI     = 11;
  localparam int W_LO     = 9;
  localparam int R_HI     = 8;
  localparam int R_LO     = 6;
  localparam int S_HI     = 5;
  localparam int S_LO     = 3;
  localparam int IMM_BIT  = 2;
  localparam int NOWR_BIT = 1;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_PASS_S = 4'h5;
  localparam logic [3:0] ALU_INC    = 4'h6;
  localparam logic [3:0] ALU_PASS_R = 4'h7;

endpackage

// File: rtl/idp_sequencer.sv
// Instruction sequencer for the 16-bit integer datapath: accepts instruction
// (and optional immediate) words and drives one execute cycle per instruction.
module idp_sequencer
  import idp_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              W_En,
  output logic [ADDR_W-1:0] W_Adr,
  output logic [ADDR_W-1:0] R_Adr,
  output logic [ADDR_W-1:0] S_Adr,
  output logic              S_Sel,
  output logic [3:0]        Alu_Op,
  output logic [DATA_W-1:0] DS,
  input  logic              C,
  input  logic              N,
  input  logic              Z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_z,
  output logic              busy,
  output logic              done
);

  state_e            state, state_nxt;
  logic [DATA_W-1:0] ir_p0;
  logic [DATA_W-1:0] ds_p0;
  logic              xfer;
  logic              ir_rsv_unused;

  assign instr_ready   = ~reset;
  assign xfer          = instr_valid & instr_ready;
  assign ir_rsv_unused = ir_p0[0];

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b0;
    W_En      = 1'b0;
    S_Sel     = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) state_nxt = instr_in[IMM_BIT] ? WAIT_IMM : EXEC;
      end
      WAIT_IMM: begin
        busy = 1'b1;
        if (xfer) state_nxt = EXEC;
      end
      EXEC: begin
        busy  = 1'b1;
        done  = 1'b1;
        W_En  = ~ir_p0[NOWR_BIT] & ~reset;
        S_Sel = ir_p0[IMM_BIT];
        // A word arriving in EXEC starts the next instruction with no bubble
        if (xfer) state_nxt = instr_in[IMM_BIT] ? WAIT_IMM : EXEC;
        else      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: instruction, immediate and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ir_p0  <= '0;
      ds_p0  <= '0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer && (state != WAIT_IMM)) ir_p0 <= instr_in;
      if (xfer && (state == WAIT_IMM)) ds_p0 <= instr_in;
      if (state == EXEC) begin
        flag_c <= C;
        flag_n <= N;
        flag_z <= Z;
      end
    end
  end

  assign Alu_Op = ir_p0[OP_HI:OP_LO];
  assign W_Adr  = ir_p0[W_HI:W_LO];
  assign R_Adr  = ir_p0[R_HI:R_LO];
  assign S_Adr  = ir_p0[S_HI:S_LO];
  assign DS     = ds_p0;

endmodule

// File: tb/tb_idp_sequencer.sv
// Scoreboard bench for idp_sequencer with a small register-file/ALU environment.
module tb_idp_sequencer;
  import idp_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        W_En;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic        S_Sel;
  logic [3:0]  Alu_Op;
  logic [15:0] DS;
  logic        C, N, Z;
  logic        flag_c, flag_n, flag_z;
  logic        busy, done;

  idp_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .W_En(W_En), .W_Adr(W_Adr), .R_Adr(R_Adr),
    .S_Adr(S_Adr), .S_Sel(S_Sel), .Alu_Op(Alu_Op), .DS(DS), .C(C), .N(N), .Z(Z),
    .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [16:0] alu(input logic [3:0] op, input logic [15:0] r, input logic [15:0] s);
    case (op)
      ALU_ADD:    return {1'b0, r} + {1'b0, s};
      ALU_SUB:    return {1'b0, r} - {1'b0, s};
      ALU_AND:    return {1'b0, r & s};
      ALU_OR:     return {1'b0, r | s};
      ALU_XOR:    return {1'b0, r ^ s};
      ALU_PASS_S: return {1'b0, s};
      ALU_INC:    return {1'b0, r} + 17'd1;
      ALU_PASS_R: return {1'b0, r};
      default:    return 17'd0;
    endcase
  endfunction

  // Environment: register file and ALU driven by the sequencer's control pins
  logic        rf_clr;
  logic [15:0] rf [8];
  logic [16:0] alu_out;
  always_comb alu_out = alu(Alu_Op, rf[R_Adr], S_Sel ? DS : rf[S_Adr]);
  assign C = alu_out[16];
  assign N = alu_out[15];
  assign Z = (alu_out[15:0] == 16'd0);
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
    end else if (W_En) begin
      rf[W_Adr] <= alu_out[15:0];
    end
  end

  // Reference model: instruction-level effect on registers, DS and flags
  typedef struct {
    logic [3:0]  op;
    logic [2:0]  w, r, s;
    logic        sel, wen;
    logic [15:0] ds;
    logic        c, n, z;
    logic [15:0] wval;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mrf [8];
  logic [15:0] last_ds;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] w, input logic [2:0] r,
                                     input logic [2:0] s, input logic imm, input logic nowr, input logic rsv);
    return {op, w, r, s, imm, nowr, rsv};
  endfunction

  task automatic send_word(input logic [15:0] w);
    instr_in    = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_in    = 16'($urandom);
  endtask

  task automatic idle(input int n, input bit in_wait);
    repeat (n) begin
      instr_valid = 1'b0;
      instr_in    = 16'($urandom);
      @(negedge clk);
      if (in_wait) begin
        chk("wait_busy", busy, 1'b1);
        chk("wait_done", done, 1'b0);
        chk("wait_wen", W_En, 1'b0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_instr(input logic [15:0] iw, input logic [15:0] immw, input int gap, input bit abort);
    exp_t        e;
    logic [16:0] a;
    logic [15:0] sval;
    e.op  = iw[15:12];
    e.w   = iw[11:9];
    e.r   = iw[8:6];
    e.s   = iw[5:3];
    e.sel = iw[2];
    if (iw[2]) begin
      send_word(iw);
      idle(gap, 1'b1);
      last_ds = immw;
      sval    = immw;
    end else begin
      sval = mrf[e.s];
    end
    a     = alu(e.op, mrf[e.r], sval);
    e.ds  = last_ds;
    e.wen = !iw[1] && !abort;
    e.c   = abort ? 1'b0 : a[16];
    e.n   = abort ? 1'b0 : a[15];
    e.z   = abort ? 1'b0 : (a[15:0] == 16'd0);
    if (e.wen) mrf[e.w] = a[15:0];
    e.wval = mrf[e.w];
    e.cyc  = cyc + 1;
    q.push_back(e);
    send_word(iw[2] ? immw : iw);
    if (abort) begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      last_ds = 16'd0;
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_ready", instr_ready, 1'b1);
      chk("abort_flags", {flag_c, flag_n, flag_z}, 3'b000);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on every execute cycle
  bit   pend = 1'b0;
  exp_t pe;
  always @(negedge clk) begin
    if (pend) begin
      chk("flag_c", flag_c, pe.c);
      chk("flag_n", flag_n, pe.n);
      chk("flag_z", flag_z, pe.z);
      chk("regval", rf[pe.w], pe.wval);
      pend = 1'b0;
    end
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        pe = q.pop_front();
        chk("exec_cycle", cyc, pe.cyc);
        chk("alu_op", Alu_Op, pe.op);
        chk("w_adr", W_Adr, pe.w);
        chk("r_adr", R_Adr, pe.r);
        chk("s_adr", S_Adr, pe.s);
        chk("s_sel", S_Sel, pe.sel);
        chk("w_en", W_En, pe.wen);
        chk("ds", DS, pe.ds);
        chk("exec_busy", busy, 1'b1);
        pend = 1'b1;
      end
    end else begin
      chk("idle_wen", W_En, 1'b0);
      chk("idle_ssel", S_Sel, 1'b0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] iw;
    int          guard;
    reset       = 1'b1;
    rf_clr      = 1'b1;
    instr_valid = 1'b1;
    instr_in    = mk(ALU_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) mrf[i] = 16'd0;
    last_ds = 16'd0;
    @(posedge clk);
    #1;
    rf_clr = 1'b0;
    // Reset held with valid high: nothing is accepted
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", instr_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_wen", W_En, 1'b0);
      chk("rst_fields", {Alu_Op, W_Adr, R_Adr, S_Adr}, 13'd0);
      chk("rst_ds", DS, 16'd0);
      chk("rst_flags", {flag_c, flag_n, flag_z}, 3'b000);
      @(posedge clk);
      #1;
    end
    reset       = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;

    send_instr(mk(ALU_PASS_S, 3'd1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0), 16'h00FF, 1, 1'b0);
    idle(1, 1'b0);
    send_instr(mk(ALU_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0), 16'h0, 0, 1'b0);
    send_instr(mk(ALU_SUB, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0), 16'h0, 0, 1'b0);
    idle(1, 1'b0);
    send_instr(mk(ALU_SUB, 3'd1, 3'd1, 3'd1, 1'b0, 1'b1, 1'b0), 16'h0, 0, 1'b0);
    idle(1, 1'b0);
    send_instr(mk(ALU_ADD, 3'd5, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1), 16'h1234, 5, 1'b0);
    idle(1, 1'b0);
    send_instr(mk(ALU_ADD, 3'd4, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0), 16'h0, 0, 1'b1);
    send_instr(mk(ALU_PASS_R, 3'd6, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0), 16'h0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      iw = mk(4'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 1'($urandom));
      send_instr(iw, 16'($urandom), $urandom_range(0, 2), ($urandom_range(0, 39) == 0));
      idle($urandom_range(0, 2), 1'b0);
    end

    guard = 0;
    while ((q.size() != 0 || pend) && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    idle(2, 1'b0);
    chk("drain_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
